// File: rtl/axi_embed_tlast.sv
// In-band tlast encoder: marks end-of-packet beats (and data that collides with
// the escape word) with an ESC + flag prefix so tlast survives a tlast-less link.
//
// state  | meaning
// IDLE   | pass-through; accepts upstream beats when the output slot is free
// FLAG   | ESC has been loaded; next free slot carries FLAG_LAST or FLAG_EMU
// DATA   | flag has been loaded; next free slot carries the held data beat
module axi_embed_tlast #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam logic [WIDTH-1:0] ESC       = 64'hDEADBEEFFEEDCAFE;
  localparam logic [WIDTH-1:0] FLAG_LAST = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] FLAG_EMU  = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLAG = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] o_tdata_q, o_tdata_d;
  logic             o_tvalid_q, o_tvalid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;

  logic slot_free;
  logic in_idle;
  logic accept;
  logic need_esc;

  assign slot_free = ~o_tvalid_q | o_tready;
  assign in_idle   = (state_q == S_IDLE);
  // accept is built from state and slot_free directly so it never depends on i_tready
  assign accept    = i_tvalid & in_idle & slot_free;
  assign need_esc  = i_tlast | (i_tdata == ESC);

  assign o_tdata  = o_tdata_q;
  assign o_tvalid = o_tvalid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      o_tdata_q   <= '0;
      o_tvalid_q  <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      o_tdata_q   <= '0;
      o_tvalid_q  <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_tdata_q   <= o_tdata_d;
      o_tvalid_q  <= o_tvalid_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && need_esc) state_d = S_FLAG;
      S_FLAG:  if (slot_free) state_d = S_DATA;
      S_DATA:  if (slot_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_tready    = 1'b0;
    o_tdata_d   = o_tdata_q;
    o_tvalid_d  = o_tvalid_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    case (state_q)
      S_IDLE: begin
        i_tready = slot_free;
        if (accept) begin
          o_tvalid_d = 1'b1;
          if (need_esc) begin
            o_tdata_d   = ESC;
            hold_data_d = i_tdata;
            hold_last_d = i_tlast;
          end else begin
            o_tdata_d = i_tdata;
          end
        end else if (slot_free) begin
          o_tvalid_d = 1'b0;
        end
      end
      S_FLAG: begin
        if (slot_free) begin
          o_tdata_d  = hold_last_q ? FLAG_LAST : FLAG_EMU;
          o_tvalid_d = 1'b1;
        end
      end
      S_DATA: begin
        if (slot_free) begin
          o_tdata_d  = hold_data_q;
          o_tvalid_d = 1'b1;
        end
      end
      default: begin
        o_tvalid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/axi_embed_tlast.md
AXI_EMBED_TLAST -- requirements
Module: axi_embed_tlast

Interface
REQ-001 Parameter WIDTH, default 64, data width; only 64 is supported because the escape word is 64 bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
REQ-004 clear  input  1  synchronous, active-high; same effect as reset on the next rising edge.
REQ-005 i_tdata  input  WIDTH  upstream data beat.
REQ-006 i_tlast  input  1  upstream end-of-packet marker.
REQ-007 i_tvalid  input  1  upstream beat valid.
REQ-008 i_tready  output  1  block accepts the upstream beat.
REQ-009 o_tdata  output  WIDTH  escape-coded stream, registered.
REQ-010 o_tvalid  output  1  output beat valid, registered.
REQ-011 o_tready  input  1  downstream accepts the output beat.

Function
REQ-012 The block SHALL encode tlast in-band so that the stream can cross a tlast-less link and be recovered by the tlast extractor.
- ESC = 64'hDEADBEEFFEEDCAFE.
- FLAG_LAST = 64'h1.
- FLAG_EMU = 64'h0.
REQ-013 An accepted beat with i_tlast=1 SHALL produce three output beats in order: ESC, FLAG_LAST, data.
REQ-014 An accepted beat with i_tlast=0 and i_tdata==ESC SHALL produce ESC, FLAG_EMU, data.
REQ-015 Every other accepted beat SHALL produce exactly one output beat carrying i_tdata unchanged.
REQ-016 An input that is both i_tlast=1 and equal to ESC SHALL be coded as tlast: ESC, FLAG_LAST, ESC.
REQ-017 The output slot is free when o_tvalid=0 or o_tready=1 (slot_free); an output beat is consumed when o_tvalid & o_tready.
REQ-018 The state machine SHALL have states IDLE, FLAG and DATA; the reset state is IDLE.
REQ-019 In IDLE, i_tready SHALL equal slot_free; this is the only combinational path from o_tready to i_tready.
REQ-020 In FLAG and DATA, i_tready SHALL be 0.
REQ-021 IDLE transitions on accept (i_tvalid & i_tready):
- Escape needed: load o_tdata=ESC, o_tvalid=1; capture i_tdata into hold_data and i_tlast into hold_last; go to FLAG.
- Otherwise: load o_tdata=i_tdata, o_tvalid=1; stay in IDLE.
REQ-022 In IDLE with no accept and slot_free, o_tvalid SHALL go to 0.
REQ-023 FLAG, when slot_free: load o_tdata = hold_last ? FLAG_LAST : FLAG_EMU, o_tvalid=1; go to DATA.
REQ-024 DATA, when slot_free: load o_tdata=hold_data, o_tvalid=1; go to IDLE.
REQ-025 While slot_free=0, o_tdata, o_tvalid, the state and the hold registers SHALL hold unchanged (AXI stability).
REQ-026 Latency from input accept to the first output beat SHALL be 1 cycle.
- Unescaped beats sustain 1 beat/cycle when o_tready=1.
- An escaped beat occupies 3 consecutive output cycles when o_tready=1.
REQ-027 Backpressure on any output beat SHALL stall the sequence in place; no beat is dropped, duplicated or reordered.

Reset
REQ-028 On reset low or clear high, the block SHALL reset to:
- state=IDLE;
- o_tvalid=0;
- o_tdata=0;
- hold_data=0, hold_last=0.
REQ-029 After reset, i_tready SHALL be 1.
REQ-030 Reset or clear in the middle of a sequence (FLAG or DATA) SHALL abandon the sequence; no remaining FLAG or data beat is emitted afterwards.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Plain stream: beats 1, 2, 3 with tlast=0 and o_tready=1 -> outputs 1, 2, 3 at one per cycle, first beat 1 cycle after accept.
- tlast: beat 64'hA5 with tlast=1 -> ESC, 64'h1, 64'hA5 on consecutive cycles; i_tready=0 for 2 cycles.
- Emulation: beat ESC with tlast=0 -> ESC, 64'h0, ESC.
- Combined: beat ESC with tlast=1 -> ESC, 64'h1, ESC.
- Backpressure: o_tready low for 3 cycles while FLAG_LAST is presented -> o_tdata is held at 64'h1 with o_tvalid=1, then the sequence resumes; the sequence is then exercised with random o_tready, and an extractor model SHALL reproduce the original data and tlast exactly.
- Reset mid-sequence: reset pulsed low while in DATA -> o_tvalid=0 immediately, i_tready=1 after release, and the held data is never emitted.
